// File: rtl/asmd_mult_pkg.sv
// asmd_mult_pkg: shared state encoding and counter sizing for the shift-and-add multiplier
package asmd_mult_pkg;

    typedef enum logic {IDLE, BUSY} state_t;

    localparam int WORD_LENGTH = 4;
    localparam int CNT_W = $clog2(WORD_LENGTH);

    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/asmd_mult_if.sv
// asmd_mult_if: operand/start request and product/ready response bundle
interface asmd_mult_if #(
    parameter int word_length = 4
);
    logic [word_length-1:0]   word0;
    logic [word_length-1:0]   word1;
    logic                     start;
    logic [2*word_length-1:0] product;
    logic                     ready;

    modport master (output word0, word1, start, input product, ready);
    modport slave  (input word0, word1, start, output product, ready);
endinterface

// File: rtl/asmd_mult_datapath.sv
// asmd_mult_datapath: operand shift registers and 2W-bit accumulating adder
module asmd_mult_datapath #(
    parameter int word_length = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic                     step,
    input  logic [word_length-1:0]   word0,
    input  logic [word_length-1:0]   word1,
    output logic [2*word_length-1:0] product
);
    logic [2*word_length-1:0] mcand;
    logic [word_length-1:0]   mplier;
    logic [2*word_length-1:0] addend;

    // add the shifted multiplicand only when the current multiplier bit is set
    always_comb addend = mplier[0] ? mcand : '0;

    // load captures operands; each step accumulates and shifts one bit position
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand   <= '0;
            mplier  <= '0;
            product <= '0;
        end else if (load) begin
            mcand   <= {{word_length{1'b0}}, word0};
            mplier  <= word1;
            product <= '0;
        end else if (step) begin
            product <= product + addend;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
        end
    end
endmodule

// File: rtl/asmd_mult.sv
// asmd_mult: sequential unsigned shift-and-add multiplier with fixed W-cycle latency
module asmd_mult
    import asmd_mult_pkg::*;
#(
    parameter int word_length = 4
) (
    input  logic       clk,
    input  logic       reset,
    asmd_mult_if.slave bus
);
    localparam int CW = cnt_width(word_length);
    localparam logic [CW-1:0] LAST = CW'(word_length - 1);

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] count;
    logic          ready_q;
    logic          load;
    logic          step;

    // state, step counter and ready flag; ready tracks the state being entered
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            ready_q <= 1'b1;
        end else begin
            state   <= next_state;
            count   <= load ? '0 : step ? count + 1'b1 : count;
            ready_q <= next_state == IDLE;
        end
    end

    // leave IDLE on start; return after the W-th busy cycle regardless of operands
    always_comb next_state = state == IDLE ? (bus.start ? BUSY : IDLE)
                                           : (count == LAST ? IDLE : BUSY);

    // datapath controls: start is honoured only while idle
    always_comb begin
        load = state == IDLE && bus.start;
        step = state == BUSY;
    end

    assign bus.ready = ready_q;

    asmd_mult_datapath #(.word_length(word_length)) u_dp (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .step    (step),
        .word0   (bus.word0),
        .word1   (bus.word1),
        .product (bus.product)
    );
endmodule

// File: tb/tb_asmd_mult.sv
// tb_asmd_mult: directed and randomized checks of product value and ready timing
module tb_asmd_mult;
    localparam int W = 4;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    asmd_mult_if #(.word_length(W)) ifc();
    asmd_mult #(.word_length(W)) dut (.clk(clk), .reset(reset), .bus(ifc));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // reference: ready low for exactly W cycles after the start edge, then product = a*b
    task automatic run_mul(input int a, input int b, input bit disturb);
        ifc.word0 = W'(a);
        ifc.word1 = W'(b);
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        for (int i = 0; i < W; i++) begin
            check("busy_ready", 16'(ifc.ready), 16'd0);
            if (disturb && i == 0) begin
                ifc.word0 = W'(1);
                ifc.word1 = W'(1);
                ifc.start = 1'b1;
            end else begin
                ifc.start = 1'b0;
            end
            tick();
        end
        check("done_ready", 16'(ifc.ready), 16'd1);
        check("done_product", 16'(ifc.product), 16'(a * b));
    endtask

    task automatic hold_check(input int exp, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check("hold_ready", 16'(ifc.ready), 16'd1);
            check("hold_product", 16'(ifc.product), 16'(exp));
        end
    endtask

    initial begin
        reset     = 1'b1;
        ifc.start = 1'b0;
        ifc.word0 = '0;
        ifc.word1 = '0;
        tick();
        tick();
        check("reset_ready", 16'(ifc.ready), 16'd1);
        check("reset_product", 16'(ifc.product), 16'd0);
        reset = 1'b0;

        run_mul(4, 5, 1'b0);
        hold_check(20, 3);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("idle_reset_product", 16'(ifc.product), 16'd0);
        check("idle_reset_ready", 16'(ifc.ready), 16'd1);
        run_mul(15, 15, 1'b0);
        hold_check(225, 3);

        run_mul(0, 9, 1'b0);
        run_mul(9, 0, 1'b0);
        run_mul(7, 3, 1'b1);

        ifc.word0 = W'(6);
        ifc.word1 = W'(6);
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_ready", 16'(ifc.ready), 16'd1);
        check("abort_product", 16'(ifc.product), 16'd0);
        hold_check(0, 2);
        run_mul(6, 6, 1'b0);

        ifc.word0 = W'(2);
        ifc.word1 = W'(3);
        ifc.start = 1'b1;
        for (int i = 0; i < W + 1; i++) tick();
        check("held_ready", 16'(ifc.ready), 16'd1);
        check("held_product", 16'(ifc.product), 16'd6);
        tick();
        check("restart_ready", 16'(ifc.ready), 16'd0);
        ifc.start = 1'b0;
        for (int i = 0; i < W - 1; i++) begin
            tick();
            check("restart_busy", 16'(ifc.ready), 16'd0);
        end
        tick();
        check("restart_done_ready", 16'(ifc.ready), 16'd1);
        check("restart_done_product", 16'(ifc.product), 16'd6);

        for (int a = 0; a < (1 << W); a++)
            for (int b = 0; b < (1 << W); b++)
                run_mul(a, b, 1'b0);

        for (int t = 0; t < 40; t++) begin
            int a, b, gap, prev;
            a    = int'($urandom_range(0, (1 << W) - 1));
            b    = int'($urandom_range(0, (1 << W) - 1));
            gap  = int'($urandom_range(0, 2));
            prev = int'(ifc.product);
            hold_check(prev, gap);
            run_mul(a, b, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
